// File: rtl/subbyte_sched.sv
`default_nettype none
// ============================================================================
//  Module      : subbyte_sched
//  Description : Shares one narrow S-box bank between the round datapath
//                (128-bit SubBytes, sequenced in beats) and key expansion
//                (32-bit SubWord) with round-robin arbitration and
//                valid/ready result buffering.
//  Revision    : 1.0  initial release
// ============================================================================
module subbyte_sched #(
   parameter int LANES = 4            // 4, 8 or 16 sbox instances in the bank
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 state_valid_in,
   output logic                 state_ready_out,
   input  logic [127:0]         state_data_in,
   output logic                 state_valid_out,
   input  logic                 state_ready_in,
   output logic [127:0]         state_data_out,
   input  logic                 key_valid_in,
   output logic                 key_ready_out,
   input  logic [31:0]          key_word_in,
   output logic                 key_valid_out,
   output logic [31:0]          key_word_out,
   output logic [8*LANES-1:0]   sbox_lane_out,
   input  logic [8*LANES-1:0]   sbox_lane_in,
   output logic                 busy
);

   localparam int NBEAT = 16 / LANES;
   localparam int LW    = 8 * LANES;
   localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
   localparam logic [BW-1:0] C_LAST_BEAT = BW'(NBEAT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2,
      K_RUN  = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_last_key;      // 1: last grant went to key expansion
   logic [BW-1:0]   r_beat;
   logic [127:0]    r_buf;
   logic [127:0]    r_res;
   logic [31:0]     r_word;
   logic [31:0]     r_key_out;
   logic            r_key_vld;
   logic            r_st_vld;
   logic            w_st_rdy;
   logic            w_key_rdy;
   logic [LW-1:0]   w_lane_out;

   // Arbitration, next-state decode and bank-lane drive.
   always_comb begin
      w_next     = r_state;
      w_st_rdy   = 1'b0;
      w_key_rdy  = 1'b0;
      w_lane_out = '0;
      case (r_state)
         IDLE: begin
            // On a tie the requester that did not win last time is granted.
            w_st_rdy  = state_valid_in & (~key_valid_in | r_last_key);
            w_key_rdy = key_valid_in & (~state_valid_in | ~r_last_key);
            if (w_st_rdy) begin
               w_next = S_RUN;
            end else if (w_key_rdy) begin
               w_next = K_RUN;
            end
         end
         S_RUN: begin
            w_lane_out = r_buf[r_beat*LW +: LW];
            if (r_beat == C_LAST_BEAT) begin
               w_next = S_HOLD;
            end
         end
         S_HOLD: begin
            if (state_ready_in) begin
               w_next = IDLE;
            end
         end
         K_RUN: begin
            // Upper lanes stay at zero so they do not toggle for a key word.
            w_lane_out[31:0] = r_word;
            w_next           = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Input capture, beat sequencing and result buffering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_key <= 1'b1;
         r_beat     <= '0;
         r_buf      <= '0;
         r_res      <= '0;
         r_word     <= '0;
         r_key_out  <= '0;
         r_key_vld  <= 1'b0;
         r_st_vld   <= 1'b0;
      end else begin
         r_key_vld <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_st_rdy) begin
                  r_buf      <= state_data_in;
                  r_beat     <= '0;
                  r_last_key <= 1'b0;
               end else if (w_key_rdy) begin
                  r_word     <= key_word_in;
                  r_last_key <= 1'b1;
               end
            end
            S_RUN: begin
               r_res[r_beat*LW +: LW] <= sbox_lane_in;
               if (r_beat == C_LAST_BEAT) begin
                  r_beat   <= '0;
                  r_st_vld <= 1'b1;
               end else begin
                  r_beat <= r_beat + 1'b1;
               end
            end
            S_HOLD: begin
               if (state_ready_in) begin
                  r_st_vld <= 1'b0;
               end
            end
            K_RUN: begin
               r_key_out <= sbox_lane_in[31:0];
               r_key_vld <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign state_ready_out = w_st_rdy;
   assign key_ready_out   = w_key_rdy;
   assign state_valid_out = r_st_vld;
   assign state_data_out  = r_res;
   assign key_valid_out   = r_key_vld;
   assign key_word_out    = r_key_out;
   assign sbox_lane_out   = w_lane_out;
   assign busy            = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_subbyte_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_subbyte_sched
//  Description : Self-checking bench for subbyte_sched (LANES=4 and 16) with
//                a transaction-level reference model and a FIPS-197 sbox bank.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_subbyte_sched;

   localparam int NBEAT = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          state_valid_in, state_ready_out, state_valid_out, state_ready_in;
   logic [127:0]  state_data_in, state_data_out;
   logic          key_valid_in, key_ready_out, key_valid_out, busy;
   logic [31:0]   key_word_in, key_word_out;
   logic [31:0]   lane_out, lane_in;

   logic          s16_vi, s16_ro, s16_vo, s16_ri, k16_vi, k16_ro, k16_vo, busy16;
   logic [127:0]  s16_di, s16_do, lane16_out, lane16_in;
   logic [31:0]   k16_wi, k16_wo;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   subbyte_sched #(.LANES(4)) dut (
      .clk(clk), .rst(rst),
      .state_valid_in(state_valid_in), .state_ready_out(state_ready_out),
      .state_data_in(state_data_in), .state_valid_out(state_valid_out),
      .state_ready_in(state_ready_in), .state_data_out(state_data_out),
      .key_valid_in(key_valid_in), .key_ready_out(key_ready_out),
      .key_word_in(key_word_in), .key_valid_out(key_valid_out),
      .key_word_out(key_word_out), .sbox_lane_out(lane_out),
      .sbox_lane_in(lane_in), .busy(busy)
   );

   subbyte_sched #(.LANES(16)) dut16 (
      .clk(clk), .rst(rst),
      .state_valid_in(s16_vi), .state_ready_out(s16_ro),
      .state_data_in(s16_di), .state_valid_out(s16_vo),
      .state_ready_in(s16_ri), .state_data_out(s16_do),
      .key_valid_in(k16_vi), .key_ready_out(k16_ro),
      .key_word_in(k16_wi), .key_valid_out(k16_vo),
      .key_word_out(k16_wo), .sbox_lane_out(lane16_out),
      .sbox_lane_in(lane16_in), .busy(busy16)
   );

   // GF(2^8) multiply with the AES polynomial.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   // AES sbox: multiplicative inverse (x^254) followed by the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] p;
      logic [7:0] s;
      logic [7:0] r;
      logic [7:0] y;
      p = 8'h01;
      s = x;
      for (int k = 1; k < 8; k++) begin
         s = gmul(s, s);
         p = gmul(p, s);
      end
      y = p;
      r = p;
      for (int k = 0; k < 4; k++) begin
         r = {r[6:0], r[7]};
         y = y ^ r;
      end
      return y ^ 8'h63;
   endfunction

   function automatic logic [127:0] subbytes(input logic [127:0] v);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(v[8*i +: 8]);
      return o;
   endfunction

   function automatic logic [31:0] subword(input logic [31:0] v);
      logic [31:0] o;
      o = '0;
      for (int i = 0; i < 4; i++) o[8*i +: 8] = sbox(v[8*i +: 8]);
      return o;
   endfunction

   // Combinational sbox banks.
   always_comb begin
      lane_in = '0;
      for (int i = 0; i < 4; i++) lane_in[8*i +: 8] = sbox(lane_out[8*i +: 8]);
   end

   always_comb begin
      lane16_in = '0;
      for (int i = 0; i < 16; i++) lane16_in[8*i +: 8] = sbox(lane16_out[8*i +: 8]);
   end

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model state (transaction level).
   int            cyc = 0;
   int            s_due = -1;         // cycle in which the state result must appear
   bit            s_hold = 1'b0;      // state result outstanding
   bit            s_active = 1'b0;    // state op in flight (accepted, not yet taken)
   logic [127:0]  s_exp = '0;
   int            k_due = -10;
   int            k_acc = -10;
   logic [31:0]   k_exp = '0;
   logic [31:0]   k_last = '0;
   bit            last_state = 1'b0;  // last grant went to the state requester
   logic [127:0]  cap_data = '0;
   logic [31:0]   cap_key = '0;

   task automatic model_reset();
      s_due = -1; s_hold = 1'b0; s_active = 1'b0;
      k_due = -10; k_acc = -10; k_last = '0; last_state = 1'b0;
   endtask

   // Asynchronous reset pulse, issued just after a rising edge.
   task automatic do_reset();
      state_valid_in = 1'b0; state_data_in = '0; state_ready_in = 1'b0;
      key_valid_in = 1'b0; key_word_in = '0;
      rst = 1'b1;
      #1;
      check_eq("rst_state_valid", 128'(state_valid_out), 128'd0);
      check_eq("rst_state_data", state_data_out, 128'd0);
      check_eq("rst_key_valid", 128'(key_valid_out), 128'd0);
      check_eq("rst_key_word", 128'(key_word_out), 128'd0);
      check_eq("rst_busy", 128'(busy), 128'd0);
      check_eq("rst_lanes", 128'(lane_out), 128'd0);
      check_eq("rst_busy16", 128'(busy16), 128'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // One clock cycle: check outputs against the model, drive inputs,
   // check the arbitration, advance the model across the edge.
   task automatic step(input bit sv, input logic [127:0] sd, input bit rin,
                       input bit kv, input logic [31:0] kw);
      bit exp_sv, exp_busy, exp_sr, exp_kr;
      exp_sv = s_hold || (s_due == cyc);
      if (s_due == cyc) s_hold = 1'b1;
      check_eq("state_valid_out", 128'(state_valid_out), 128'(exp_sv));
      if (exp_sv) begin
         check_eq("state_data_out", state_data_out, s_exp);
         cap_data = state_data_out;
      end
      check_eq("key_valid_out", 128'(key_valid_out), 128'(k_due == cyc));
      if (k_due == cyc) begin
         k_last  = k_exp;
         cap_key = key_word_out;
      end
      check_eq("key_word_out", 128'(key_word_out), 128'(k_last));
      exp_busy = s_active || (k_acc == cyc - 1);
      check_eq("busy", 128'(busy), 128'(exp_busy));

      state_valid_in = sv; state_data_in = sd; state_ready_in = rin;
      key_valid_in = kv; key_word_in = kw;
      #1;
      exp_sr = !exp_busy && sv && (!kv || !last_state);
      exp_kr = !exp_busy && kv && (!sv || last_state);
      check_eq("state_ready_out", 128'(state_ready_out), 128'(exp_sr));
      check_eq("key_ready_out", 128'(key_ready_out), 128'(exp_kr));

      if (exp_sv && rin) begin
         s_hold = 1'b0; s_active = 1'b0; s_due = -1;
      end
      if (exp_sr) begin
         s_exp = subbytes(sd); s_due = cyc + NBEAT + 1; s_active = 1'b1; last_state = 1'b1;
      end
      if (exp_kr) begin
         k_exp = subword(kw); k_due = cyc + 2; k_acc = cyc; last_state = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [127:0] d;
      s16_vi = 1'b0; s16_di = '0; s16_ri = 1'b0; k16_vi = 1'b0; k16_wi = '0;
      #1;
      do_reset();

      // State of all-zero bytes, taken immediately.
      step(1'b1, 128'd0, 1'b1, 1'b0, 32'd0);
      repeat (6) step(1'b0, 128'd0, 1'b1, 1'b0, 32'd0);
      check_eq("t1_data", cap_data, {16{8'h63}});

      // Key word alone.
      step(1'b0, 128'd0, 1'b1, 1'b1, 32'hcf4f3c09);
      repeat (3) step(1'b0, 128'd0, 1'b1, 1'b0, 32'd0);
      check_eq("t2_key", 128'(cap_key), 128'(32'h8a84eb01));

      // Tie from reset: state first, then key, then state again.
      do_reset();
      repeat (12) step(1'b1, {16{8'h53}}, 1'b1, 1'b1, 32'h01020304);
      check_eq("t3_data", cap_data, {16{8'hED}});
      repeat (6) step(1'b0, 128'd0, 1'b1, 1'b0, 32'd0);

      // Backpressure on the state result while key expansion waits.
      d = {$urandom, $urandom, $urandom, $urandom};
      step(1'b1, d, 1'b0, 1'b0, 32'd0);
      repeat (14) step(1'b0, 128'd0, 1'b0, 1'b1, $urandom);
      step(1'b0, 128'd0, 1'b1, 1'b1, 32'h00112233);
      repeat (4) step(1'b0, 128'd0, 1'b0, 1'b0, 32'd0);

      // Reset in the second S_RUN beat, then a fresh operation.
      step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 32'd0);
      step(1'b0, 128'd0, 1'b1, 1'b0, 32'd0);
      do_reset();
      step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 32'd0);
      repeat (6) step(1'b0, 128'd0, 1'b1, 1'b0, 32'd0);

      // Randomized traffic on both requesters and the result handshake.
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
              ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom);
      end
      repeat (8) step(1'b0, 128'd0, 1'b1, 1'b0, 32'd0);

      // Sixteen-lane bank: a whole state in one beat, key lanes above 3 idle.
      s16_vi = 1'b1; s16_di = '0; s16_ri = 1'b1;
      #1;
      check_eq("l16_ready", 128'(s16_ro), 128'd1);
      @(posedge clk); #1;
      s16_vi = 1'b0;
      check_eq("l16_valid_early", 128'(s16_vo), 128'd0);
      @(posedge clk); #1;
      check_eq("l16_valid", 128'(s16_vo), 128'd1);
      check_eq("l16_data", s16_do, {16{8'h63}});
      @(posedge clk); #1;
      check_eq("l16_busy", 128'(busy16), 128'd0);
      k16_vi = 1'b1; k16_wi = 32'hcf4f3c09;
      #1;
      check_eq("l16_key_ready", 128'(k16_ro), 128'd1);
      @(posedge clk); #1;
      k16_vi = 1'b0;
      check_eq("l16_upper_lanes", 128'(lane16_out[127:32]), 128'd0);
      check_eq("l16_key_lanes", 128'(lane16_out[31:0]), 128'(32'hcf4f3c09));
      @(posedge clk); #1;
      check_eq("l16_key_valid", 128'(k16_vo), 128'd1);
      check_eq("l16_key_word", 128'(k16_wo), 128'(32'h8a84eb01));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
